// File: rtl/che_hist_stat_pkg.sv
// Shared CLAHE defaults for the histogram stage.
// Parameter defaults used by che_hist_stat and che_hist_clip.
package che_hist_stat_pkg;

    localparam int CHE_GRAY_LEVEAL  = 256;
    localparam int CHE_DAT_PIX_WD   = 8;
    localparam int CHE_TILE_SIZ     = 64;
    localparam int CHE_HIST_BIN_WD  = 13;
    localparam int CHE_CLIP_LIMIT   = 64;

    localparam int CHE_TILE_PIX     = CHE_TILE_SIZ * CHE_TILE_SIZ;

endpackage : che_hist_stat_pkg

// File: rtl/che_hist_clip.sv
// Clip sweep over the parent's bin array, with an excess accumulator and
// the uniform redistribution increment.
module che_hist_clip
    import che_hist_stat_pkg::*;
#(
    parameter int GRAY_LEVEAL = CHE_GRAY_LEVEAL,
    parameter int HIST_BIN_WD = CHE_HIST_BIN_WD,
    parameter int CLIP_LIMIT  = CHE_CLIP_LIMIT,
    parameter int IDX_WD      = $clog2(CHE_GRAY_LEVEAL)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr_i,
    input  logic                   start_i,
    input  logic [HIST_BIN_WD-1:0] bin_i,
    output logic [IDX_WD-1:0]      idx_o,
    output logic                   wr_o,
    output logic [HIST_BIN_WD-1:0] wr_val_o,
    output logic                   done_o,
    output logic [HIST_BIN_WD-1:0] add_o
);

    localparam logic [HIST_BIN_WD-1:0] LIMIT    = HIST_BIN_WD'(CLIP_LIMIT);
    localparam logic [IDX_WD-1:0]      IDX_LAST = IDX_WD'(GRAY_LEVEAL - 1);

    logic                   busy_q,   busy_d;
    logic [IDX_WD-1:0]      idx_q,    idx_d;
    logic [HIST_BIN_WD-1:0] excess_q, excess_d;
    logic                   over_s;
    logic [HIST_BIN_WD-1:0] excess_inc_s;

    // Clip decision for the bin currently addressed by the sweep.
    always_comb begin
        over_s       = (bin_i > LIMIT);
        wr_val_o     = bin_i;
        excess_inc_s = {HIST_BIN_WD{1'b0}};
        if (over_s) begin
            wr_val_o     = LIMIT;
            excess_inc_s = bin_i - LIMIT;
        end else begin
            wr_val_o     = bin_i;
            excess_inc_s = {HIST_BIN_WD{1'b0}};
        end
    end

    // Sweep index, busy flag and excess next-state.
    always_comb begin
        busy_d   = busy_q;
        idx_d    = idx_q;
        excess_d = excess_q;
        if (clr_i) begin
            busy_d   = 1'b0;
            idx_d    = {IDX_WD{1'b0}};
            excess_d = {HIST_BIN_WD{1'b0}};
        end else if (start_i) begin
            busy_d   = 1'b1;
            idx_d    = {IDX_WD{1'b0}};
            excess_d = {HIST_BIN_WD{1'b0}};
        end else if (busy_q) begin
            excess_d = excess_q + excess_inc_s;
            idx_d    = idx_q + IDX_WD'(1);
            if (idx_q == IDX_LAST) begin
                busy_d = 1'b0;
            end else begin
                busy_d = 1'b1;
            end
        end else begin
            busy_d   = busy_q;
            idx_d    = idx_q;
            excess_d = excess_q;
        end
    end

    // Sweep state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= 1'b0;
            idx_q    <= {IDX_WD{1'b0}};
            excess_q <= {HIST_BIN_WD{1'b0}};
        end else begin
            busy_q   <= busy_d;
            idx_q    <= idx_d;
            excess_q <= excess_d;
        end
    end

    assign idx_o  = idx_q;
    assign wr_o   = busy_q;
    assign done_o = busy_q && (idx_q == IDX_LAST);
    // Remainder of excess / GRAY_LEVEAL is intentionally dropped.
    assign add_o  = excess_q >> IDX_WD;

endmodule : che_hist_clip

// File: rtl/che_hist_stat.sv
// Per-tile CLAHE histogram producer: count, clip, redistribute, then
// present the packed histogram on a valid/ready output.
module che_hist_stat
    import che_hist_stat_pkg::*;
#(
    parameter int GRAY_LEVEAL = CHE_GRAY_LEVEAL,
    parameter int DAT_PIX_WD  = CHE_DAT_PIX_WD,
    parameter int TILE_SIZ    = CHE_TILE_SIZ,
    parameter int HIST_BIN_WD = CHE_HIST_BIN_WD,
    parameter int CLIP_LIMIT  = CHE_CLIP_LIMIT
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               vld_i,
    output logic                               rdy_o,
    input  logic [DAT_PIX_WD-1:0]              dat_i,
    output logic                               vld_o,
    input  logic                               rdy_i,
    output logic [GRAY_LEVEAL*HIST_BIN_WD-1:0] hist_o
);

    localparam int NPIX   = TILE_SIZ * TILE_SIZ;
    localparam int CNT_WD = $clog2(NPIX) + 1;
    localparam logic [CNT_WD-1:0] CNT_LAST = CNT_WD'(NPIX - 1);

    typedef enum logic [2:0] {
        ST_ACC    = 3'd0,
        ST_CLIP   = 3'd1,
        ST_REDIST = 3'd2,
        ST_OUT    = 3'd3,
        ST_CLR    = 3'd4
    } state_t;

    state_t                 state_q;
    logic [CNT_WD-1:0]      cnt_q;
    logic                   vld_q;
    logic [HIST_BIN_WD-1:0] bin_q [GRAY_LEVEAL];
    logic [HIST_BIN_WD-1:0] bin_d [GRAY_LEVEAL];

    logic                   acc_s;
    logic                   last_pix_s;
    logic                   clr_s;
    logic [DAT_PIX_WD-1:0]  clip_idx_s;
    logic                   clip_wr_s;
    logic [HIST_BIN_WD-1:0] clip_val_s;
    logic                   clip_done_s;
    logic [HIST_BIN_WD-1:0] clip_add_s;

    assign rdy_o      = (state_q == ST_ACC);
    assign acc_s      = vld_i && rdy_o;
    assign last_pix_s = acc_s && (cnt_q == CNT_LAST);
    assign clr_s      = (state_q == ST_CLR);
    assign vld_o      = vld_q;

    che_hist_clip #(
        .GRAY_LEVEAL (GRAY_LEVEAL),
        .HIST_BIN_WD (HIST_BIN_WD),
        .CLIP_LIMIT  (CLIP_LIMIT),
        .IDX_WD      (DAT_PIX_WD)
    ) u_clip (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (clr_s),
        .start_i  (last_pix_s),
        .bin_i    (bin_q[clip_idx_s]),
        .idx_o    (clip_idx_s),
        .wr_o     (clip_wr_s),
        .wr_val_o (clip_val_s),
        .done_o   (clip_done_s),
        .add_o    (clip_add_s)
    );

    // Tile control FSM with pixel counter and registered valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ACC;
            cnt_q   <= {CNT_WD{1'b0}};
            vld_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (acc_s) begin
                        cnt_q <= cnt_q + CNT_WD'(1);
                        if (last_pix_s) begin
                            state_q <= ST_CLIP;
                        end else begin
                            state_q <= ST_ACC;
                        end
                    end else begin
                        cnt_q <= cnt_q;
                    end
                end
                ST_CLIP: begin
                    if (clip_done_s) begin
                        state_q <= ST_REDIST;
                    end else begin
                        state_q <= ST_CLIP;
                    end
                end
                ST_REDIST: begin
                    state_q <= ST_OUT;
                    vld_q   <= 1'b1;
                end
                ST_OUT: begin
                    if (rdy_i) begin
                        state_q <= ST_CLR;
                        vld_q   <= 1'b0;
                    end else begin
                        vld_q   <= 1'b1;
                    end
                end
                ST_CLR: begin
                    state_q <= ST_ACC;
                    cnt_q   <= {CNT_WD{1'b0}};
                    vld_q   <= 1'b0;
                end
                default: begin
                    state_q <= ST_ACC;
                    cnt_q   <= {CNT_WD{1'b0}};
                    vld_q   <= 1'b0;
                end
            endcase
        end
    end

    // Bin next-state: count, clip write-back, parallel redistribution, clear.
    always_comb begin
        bin_d = bin_q;
        case (state_q)
            ST_ACC: begin
                if (acc_s) begin
                    bin_d[dat_i] = bin_q[dat_i] + HIST_BIN_WD'(1);
                end else begin
                    bin_d = bin_q;
                end
            end
            ST_CLIP: begin
                if (clip_wr_s) begin
                    bin_d[clip_idx_s] = clip_val_s;
                end else begin
                    bin_d = bin_q;
                end
            end
            ST_REDIST: begin
                for (int k = 0; k < GRAY_LEVEAL; k++) begin
                    bin_d[k] = bin_q[k] + clip_add_s;
                end
            end
            ST_CLR: begin
                for (int k = 0; k < GRAY_LEVEAL; k++) begin
                    bin_d[k] = {HIST_BIN_WD{1'b0}};
                end
            end
            default: begin
                bin_d = bin_q;
            end
        endcase
    end

    // Bin register array.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < GRAY_LEVEAL; k++) begin
                bin_q[k] <= {HIST_BIN_WD{1'b0}};
            end
        end else begin
            bin_q <= bin_d;
        end
    end

    for (genvar g = 0; g < GRAY_LEVEAL; g++) begin : g_pack
        assign hist_o[HIST_BIN_WD*g +: HIST_BIN_WD] = bin_q[g];
    end

endmodule : che_hist_stat

// File: tb/tb_che_hist_stat.sv
// Self-checking bench for che_hist_stat against a count/clip/redistribute
// reference model built from plain arithmetic.
module tb_che_hist_stat;

    localparam int G    = 256;
    localparam int PW   = 8;
    localparam int W    = 13;
    localparam int TS   = 64;
    localparam int NPIX = TS * TS;
    localparam int L    = 64;
    localparam int LAT  = G + 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              vld_i;
    logic              rdy_o;
    logic [PW-1:0]     dat_i;
    logic              vld_o;
    logic              rdy_i;
    logic [G*W-1:0]    hist_o;

    int checks = 0;
    int errors = 0;
    int pix     [NPIX];
    int exp_bin [G];

    che_hist_stat #(
        .GRAY_LEVEAL (G),
        .DAT_PIX_WD  (PW),
        .TILE_SIZ    (TS),
        .HIST_BIN_WD (W),
        .CLIP_LIMIT  (L)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .vld_i  (vld_i),
        .rdy_o  (rdy_o),
        .dat_i  (dat_i),
        .vld_o  (vld_o),
        .rdy_i  (rdy_i),
        .hist_o (hist_o)
    );

    always #5 clk = ~clk;

    function automatic int get_bin(input int k);
        return int'(hist_o[k*W +: W]);
    endfunction

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: histogram of pix[], clip at L, add floor(excess/G) to every bin.
    task automatic compute_model();
        int excess;
        excess = 0;
        for (int k = 0; k < G; k++) exp_bin[k] = 0;
        for (int i = 0; i < NPIX; i++) exp_bin[pix[i]] += 1;
        for (int k = 0; k < G; k++) begin
            if (exp_bin[k] > L) begin
                excess += exp_bin[k] - L;
                exp_bin[k] = L;
            end
        end
        for (int k = 0; k < G; k++) exp_bin[k] += excess / G;
    endtask

    task automatic check_hist(input string tag);
        int bad, first;
        bad = 0;
        first = -1;
        for (int k = 0; k < G; k++) begin
            if (get_bin(k) != exp_bin[k]) begin
                bad++;
                if (first < 0) first = k;
            end
        end
        checks++;
        assert (bad == 0) else begin
            errors++;
            $error("FAIL %s: %0d bins differ, bin %0d observed %0d expected %0d",
                   tag, bad, first, get_bin(first), exp_bin[first]);
        end
    endtask

    task automatic check_zero(input string tag);
        int nz;
        nz = 0;
        for (int k = 0; k < G; k++) if (get_bin(k) != 0) nz++;
        check(tag, nz, 0);
    endtask

    // Feed pix[0..n-1]; returns right after the edge accepting the last one.
    task automatic send_tile(input string tag, input int n, input bit gapped);
        int i, guard;
        i = 0;
        guard = 0;
        while (i < n && guard < 20 * n) begin
            @(negedge clk);
            guard++;
            if (gapped && $urandom_range(0, 1) == 0) begin
                vld_i = 1'b0;
                dat_i = PW'($urandom);
            end else begin
                vld_i = 1'b1;
                dat_i = PW'(pix[i]);
            end
            @(posedge clk);
            if (vld_i && rdy_o) i++;
        end
        check({tag, "_accepted"}, i, n);
    endtask

    // Waits for vld_o while spraying ignored pixels; checks clip latency.
    task automatic wait_vld(input string tag, output bit ok);
        int lat;
        lat = 0;
        for (int k = 1; k <= LAT + 100; k++) begin
            @(negedge clk);
            vld_i = 1'b1;
            dat_i = PW'($urandom);
            if (k == 1) check({tag, "_rdy_clip"}, rdy_o, 0);
            if (vld_o) begin
                lat = k;
                break;
            end
        end
        check({tag, "_latency"}, lat, LAT);
        ok = (lat != 0);
    endtask

    // Holds off the consumer for `hold` cycles, then completes the handshake.
    task automatic handshake(input string tag, input int hold);
        logic [G*W-1:0] snap;
        int moved, rdy_bad, vld_bad;
        snap = hist_o;
        moved = 0;
        rdy_bad = 0;
        vld_bad = 0;
        for (int j = 0; j < hold; j++) begin
            @(negedge clk);
            vld_i = 1'b1;
            dat_i = PW'($urandom);
            if (hist_o !== snap) moved++;
            if (rdy_o !== 1'b0) rdy_bad++;
            if (vld_o !== 1'b1) vld_bad++;
        end
        if (hold > 0) begin
            check({tag, "_hist_stable"}, moved, 0);
            check({tag, "_rdy_low_hold"}, rdy_bad, 0);
            check({tag, "_vld_held"}, vld_bad, 0);
        end
        @(negedge clk);
        rdy_i = 1'b1;
        @(negedge clk);
        rdy_i = 1'b0;
        vld_i = 1'b0;
        check({tag, "_vld_clr"}, vld_o, 0);
        check({tag, "_rdy_clr"}, rdy_o, 0);
        @(negedge clk);
        check({tag, "_rdy_after"}, rdy_o, 1);
        check_zero({tag, "_cleared"});
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        vld_i = 1'b1;
        dat_i = PW'($urandom);
        @(negedge clk);
        rst = 1'b0;
        vld_i = 1'b0;
        check({tag, "_vld"}, vld_o, 0);
        check({tag, "_rdy"}, rdy_o, 1);
        check_zero({tag, "_bins"});
    endtask

    task automatic run_tile(input string tag, input bit gapped, input int hold);
        bit ok;
        compute_model();
        send_tile(tag, NPIX, gapped);
        wait_vld(tag, ok);
        if (ok) begin
            check_hist(tag);
            handshake(tag, hold);
        end else begin
            do_reset({tag, "_recover"});
        end
    endtask

    task automatic fill_random(input int hi);
        for (int i = 0; i < NPIX; i++) pix[i] = $urandom_range(0, hi);
    endtask

    initial begin
        bit ok;
        int v;
        rst   = 1'b1;
        vld_i = 1'b0;
        rdy_i = 1'b0;
        dat_i = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_vld", vld_o, 0);
        check("reset_rdy", rdy_o, 1);
        check_zero("reset_hist");

        // Uniform tile: 16 per bin, nothing clipped.
        for (int i = 0; i < NPIX; i++) pix[i] = i % G;
        compute_model();
        send_tile("uniform", NPIX, 1'b0);
        wait_vld("uniform", ok);
        check("uniform_bin0", get_bin(0), 16);
        check_hist("uniform");
        handshake("uniform", 0);

        // Single value: 64 + 4032/256 = 79, others 15.
        for (int i = 0; i < NPIX; i++) pix[i] = 7;
        compute_model();
        send_tile("single", NPIX, 1'b0);
        wait_vld("single", ok);
        check("single_bin7", get_bin(7), 79);
        check("single_bin0", get_bin(0), 15);
        check_hist("single");
        handshake("single", 0);

        // Boundary: bin3 = 64 stays, bin4 = 65 clips to 64, excess too small to spread.
        v = 0;
        for (int i = 0; i < NPIX; i++) begin
            if (i < 64) pix[i] = 3;
            else if (i < 129) pix[i] = 4;
            else begin
                while (v == 3 || v == 4) v = (v + 1) % G;
                pix[i] = v;
                v = (v + 1) % G;
            end
        end
        compute_model();
        send_tile("boundary", NPIX, 1'b0);
        wait_vld("boundary", ok);
        check("boundary_bin3", get_bin(3), 64);
        check("boundary_bin4", get_bin(4), 64);
        check_hist("boundary");
        handshake("boundary", 0);

        // Backpressure on a heavily clipped random tile.
        fill_random(31);
        run_tile("backpressure", 1'b0, 100);

        // Gapped uniform tile.
        for (int i = 0; i < NPIX; i++) pix[i] = i % G;
        run_tile("gapped", 1'b1, 0);

        // Reset mid-tile, then a fresh full random tile.
        fill_random(G - 1);
        send_tile("partial", 1000, 1'b0);
        do_reset("rst_mid");
        fill_random(63);
        run_tile("after_mid", 1'b1, 3);

        // Reset while presenting a result, then another tile.
        fill_random(G - 1);
        compute_model();
        send_tile("to_out", NPIX, 1'b0);
        wait_vld("to_out", ok);
        check_hist("to_out");
        do_reset("rst_out");
        fill_random(15);
        run_tile("after_out", 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_che_hist_stat
